dm_block_mover: RTL and testbench

- Bus-initiator DMA engine for the data memory / memory-mapped IO responder.
- Drives the responder's A, WD and WE and samples its asynchronous RD. Copies LEN 32-bit words from SRC to DST.
- Per-side "fixed address" mode streams words from or to the IO port at 32'hFFFFFFFC, e.g. CPUIn into memory, or a memory buffer out to CPUOut.
- Sits beside the CPU data port; the top-level mux gives the bus to the mover while BUSY is high.

---
 rtl/dm_pkg.sv | 26 ++
 rtl/dm_range_check.sv | 56 +++++
 rtl/dm_block_mover.sv | 183 ++++++++++++++++++
 tb/tb_dm_block_mover.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg
// Shared types and constants for the block mover and its range checker.
//   mover_state_t : FSM state encoding of the mover
//   IO_ADDR       : memory-mapped IO word address (CPUIn on read, CPUOut on write)
//   WORD_BYTES    : pointer stride for incrementing sides
//   word_aligned  : true when the low two address bits are zero
// ---------------------------------------------------------------------------
package dm_pkg;

  // ST_RD is prefixed so it cannot collide with the responder read-data port RD.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } mover_state_t;

  localparam logic [31:0] IO_ADDR    = 32'hFFFF_FFFC;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dm_range_check.sv
// ---------------------------------------------------------------------------
// dm_range_check
// Combinational legality check for one side (source or destination) of a
// block move request.
//   addr : byte address of the first word
//   len  : number of words in the request
//   fix  : 1 = the address stays put for every word (IO streaming or a single
//          memory word touched repeatedly)
//   ok   : 1 = the side is legal
// Fixed side      : IO_ADDR, or an aligned word fully inside the memory.
// Incrementing    : aligned, not IO_ADDR, and the last byte inside the memory.
// A zero-length request only needs the alignment (or IO) condition.
// ---------------------------------------------------------------------------
module dm_range_check #(
  parameter int          MEM_BYTES = 1024,
  parameter int          LEN_W     = 9,
  parameter logic [31:0] IO_ADDR   = 32'hFFFF_FFFC
) (
  input  logic [31:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             fix,
  output logic             ok
);
  import dm_pkg::*;

  logic [32:0] base;
  logic [32:0] span;
  logic [32:0] end_excl;
  logic [32:0] word_end;
  logic [32:0] mem_limit;
  logic        aligned;
  logic        is_io;
  logic        len_zero;

  // 33-bit arithmetic: an address near the top of the 32-bit space must not
  // wrap around and appear to fit inside the memory.
  assign base      = {1'b0, addr};
  assign span      = {{(33-LEN_W-2){1'b0}}, len, 2'b00};
  assign end_excl  = base + span;      // one past the last byte touched
  assign word_end  = base + 33'd4;     // one past a single word
  assign mem_limit = 33'(MEM_BYTES);

  assign aligned  = word_aligned(addr[1:0]);
  assign is_io    = (addr == IO_ADDR);
  assign len_zero = (len == '0);

  always_comb begin
    ok = 1'b0;
    if (fix) begin
      ok = is_io || (aligned && (len_zero || (word_end <= mem_limit)));
    end else begin
      ok = aligned && !is_io && (len_zero || (end_excl <= mem_limit));
    end
  end

endmodule

// File: rtl/dm_block_mover.sv
// ---------------------------------------------------------------------------
// dm_block_mover
// Bus-initiator DMA engine: copies LEN 32-bit words from SRC to DST through
// the data memory / memory-mapped IO responder, one read cycle followed by
// one write cycle per word.
//
// Ports
//   CLK, RESET        : clock (rising edge), asynchronous active-high reset
//   START             : one-cycle request, only looked at in idle
//   SRC, DST, LEN     : source/destination byte address, word count
//   SRC_FIX, DST_FIX  : 1 = that side's address does not increment
//   A, WD, WE         : responder address, write data, write enable
//   RD                : responder read data (combinational from A)
//   BUSY              : mover owns the bus (read and write states)
//   DONE              : one-cycle completion pulse
//   ERR               : request rejected; raised with DONE, held until the
//                       next accepted START
//
// State    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | bus released (A=0, WE=0); waiting for START
// ST_RD    | A=source pointer; RD captured into the data register
// ST_WR    | A=destination pointer, WD=data register, WE=1; pointers step
// ST_FIN   | DONE pulse, bus released; back to idle next cycle
// ---------------------------------------------------------------------------
module dm_block_mover #(
  parameter int          MEM_BYTES = 1024,
  parameter int          LEN_W     = 9,
  parameter logic [31:0] IO_ADDR   = 32'hFFFF_FFFC
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [31:0]      SRC,
  input  logic [31:0]      DST,
  input  logic [LEN_W-1:0] LEN,
  input  logic             SRC_FIX,
  input  logic             DST_FIX,
  output logic [31:0]      A,
  output logic [31:0]      WD,
  output logic             WE,
  input  logic [31:0]      RD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);
  import dm_pkg::*;

  mover_state_t     state;
  logic [31:0]      src_ptr;
  logic [31:0]      dst_ptr;
  logic [31:0]      data_reg;
  logic [LEN_W-1:0] count;
  logic             src_fix;
  logic             dst_fix;
  logic             src_ok;
  logic             dst_ok;
  logic [31:0]      src_next;
  logic [31:0]      dst_next;
  logic             last_word;

  // Validation looks at the raw request inputs so the decision is made on
  // the same edge that latches them.
  dm_range_check #(
    .MEM_BYTES (MEM_BYTES),
    .LEN_W     (LEN_W),
    .IO_ADDR   (IO_ADDR)
  ) u_src_check (
    .addr (SRC),
    .len  (LEN),
    .fix  (SRC_FIX),
    .ok   (src_ok)
  );

  dm_range_check #(
    .MEM_BYTES (MEM_BYTES),
    .LEN_W     (LEN_W),
    .IO_ADDR   (IO_ADDR)
  ) u_dst_check (
    .addr (DST),
    .len  (LEN),
    .fix  (DST_FIX),
    .ok   (dst_ok)
  );

  assign src_next  = src_fix ? src_ptr : (src_ptr + WORD_BYTES);
  assign dst_next  = dst_fix ? dst_ptr : (dst_ptr + WORD_BYTES);
  assign last_word = (count == LEN_W'(1));

  // The data register only changes at the end of a read cycle, so it is
  // stable for the whole following write cycle.
  assign WD = data_reg;

  // A, WE, BUSY and DONE are loaded together with the next state so each is
  // a clean registered decode of the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= ST_IDLE;
      A        <= '0;
      WE       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      data_reg <= '0;
      count    <= '0;
      src_fix  <= 1'b0;
      dst_fix  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          A    <= '0;
          WE   <= 1'b0;
          BUSY <= 1'b0;
          if (START) begin
            src_ptr <= SRC;
            dst_ptr <= DST;
            count   <= LEN;
            src_fix <= SRC_FIX;
            dst_fix <= DST_FIX;
            ERR     <= 1'b0;
            if (!(src_ok && dst_ok)) begin
              ERR   <= 1'b1;
              DONE  <= 1'b1;
              state <= ST_FIN;
            end else if (LEN == '0) begin
              DONE  <= 1'b1;
              state <= ST_FIN;
            end else begin
              A     <= SRC;
              BUSY  <= 1'b1;
              state <= ST_RD;
            end
          end
        end

        ST_RD: begin
          data_reg <= RD;
          A        <= dst_ptr;
          WE       <= 1'b1;
          BUSY     <= 1'b1;
          state    <= ST_WR;
        end

        ST_WR: begin
          src_ptr <= src_next;
          dst_ptr <= dst_next;
          count   <= count - LEN_W'(1);
          WE      <= 1'b0;
          if (last_word) begin
            A     <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_FIN;
          end else begin
            // Next read address is the stepped source pointer, not the
            // stale one still held in src_ptr this cycle.
            A     <= src_next;
            BUSY  <= 1'b1;
            state <= ST_RD;
          end
        end

        ST_FIN: begin
          A     <= '0;
          WE    <= 1'b0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          A     <= '0;
          WE    <= 1'b0;
          BUSY  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_block_mover.sv
// ---------------------------------------------------------------------------
// tb_dm_block_mover
// Bench for dm_block_mover with a behavioural data memory / IO responder.
// Stimulus pushes hand-computed expected writes and DONE events into queues;
// a negedge monitor pops and compares them whenever WE or DONE is seen.
// ---------------------------------------------------------------------------
module tb_dm_block_mover;

  localparam logic [31:0] IO = 32'hFFFF_FFFC;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [31:0] SRC = '0;
  logic [31:0] DST = '0;
  logic [8:0]  LEN = '0;
  logic        SRC_FIX = 1'b0;
  logic        DST_FIX = 1'b0;
  logic [31:0] A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  logic [31:0] mem [0:255];
  logic [31:0] cpu_in = '0;
  logic [31:0] cpu_out = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_exp = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic err;
    int   cyc;
  } dn_t;

  wr_t exp_wr[$];
  dn_t exp_dn[$];
  wr_t mon_w;
  dn_t mon_d;

  dm_block_mover dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .SRC     (SRC),
    .DST     (DST),
    .LEN     (LEN),
    .SRC_FIX (SRC_FIX),
    .DST_FIX (DST_FIX),
    .A       (A),
    .WD      (WD),
    .WE      (WE),
    .RD      (RD),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Responder: IO port at IO, 1 KiB memory below it.
  assign RD = (A == IO) ? cpu_in : ((A < 32'd1024) ? mem[A[9:2]] : 32'h0);

  always @(posedge CLK) begin
    if (WE) begin
      if (A == IO) cpu_out <= WD;
      else if (A < 32'd1024) mem[A[9:2]] <= WD;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] mem_sum();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 256; i++) s = (s ^ mem[i]) + 32'(i);
    return s;
  endfunction

  // Monitor: every write and every DONE must match the next expected entry.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (WE) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got A=%h WD=%h at cyc %0d, required no write", A, WD, cyc);
        end else begin
          mon_w = exp_wr.pop_front();
          check("wr_addr", A, mon_w.addr);
          check("wr_data", WD, mon_w.data);
          check("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
        end
      end
      if (DONE) begin
        if (exp_dn.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got DONE=1 at cyc %0d, required none", cyc);
        end else begin
          mon_d = exp_dn.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_d.cyc));
          check("done_err", {31'b0, ERR}, {31'b0, mon_d.err});
        end
        done_cnt++;
      end
    end
  end

  task automatic arm(output int t0);
    @(negedge CLK);
    t0 = cyc + 1;   // cyc value during cycle 1 (after the START edge)
  endtask

  task automatic fire(input logic [31:0] s, input logic [31:0] d, input logic [8:0] l,
                      input logic sf, input logic df);
    SRC = s;
    DST = d;
    LEN = l;
    SRC_FIX = sf;
    DST_FIX = df;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input int c);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.cyc = c;
    exp_wr.push_back(w);
  endtask

  task automatic push_done(input logic e, input int c);
    dn_t x;
    x.err = e;
    x.cyc = c;
    exp_dn.push_back(x);
    done_exp++;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < done_exp && n < 200) begin
      @(negedge CLK);
      n++;
    end
    #1;
    check("done_seen", 32'(done_cnt), 32'(done_exp));
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [31:0] sum0;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[64]  = 32'h1111_1111;
    mem[65]  = 32'h2222_2222;
    mem[66]  = 32'h3333_3333;
    mem[67]  = 32'h4444_4444;
    mem[254] = 32'h5555_5555;
    mem[255] = 32'h6666_6666;

    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_A", A, 32'h0);
    check("rst_WD", WD, 32'h0);
    check("rst_WE", {31'b0, WE}, 32'h0);
    check("rst_BUSY", {31'b0, BUSY}, 32'h0);
    check("rst_DONE", {31'b0, DONE}, 32'h0);
    check("rst_ERR", {31'b0, ERR}, 32'h0);
    RESET = 1'b0;

    // 1: four-word copy 0x100 -> 0x200, with a START ignored mid-transfer
    arm(t0);
    push_wr(32'h200, 32'h1111_1111, t0 + 1);
    push_wr(32'h204, 32'h2222_2222, t0 + 3);
    push_wr(32'h208, 32'h3333_3333, t0 + 5);
    push_wr(32'h20C, 32'h4444_4444, t0 + 7);
    push_done(1'b0, t0 + 8);
    fire(32'h100, 32'h200, 9'd4, 1'b0, 1'b0);
    check("t1_busy_c1", {31'b0, BUSY}, 32'h1);
    check("t1_a_c1", A, 32'h100);
    @(negedge CLK);
    SRC = 32'h0;
    DST = 32'h0;
    LEN = 9'd1;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    wait_done();
    check("t1_mem200", mem[128], 32'h1111_1111);
    check("t1_mem204", mem[129], 32'h2222_2222);
    check("t1_mem208", mem[130], 32'h3333_3333);
    check("t1_mem20C", mem[131], 32'h4444_4444);

    // 2: zero length
    arm(t0);
    push_done(1'b0, t0);
    fire(32'h0, 32'h4, 9'd0, 1'b0, 1'b0);
    wait_done();

    // 3: source runs past the end of memory
    arm(t0);
    push_done(1'b1, t0);
    fire(32'h3FC, 32'h0, 9'd2, 1'b0, 1'b0);
    wait_done();
    check("t3_err_held", {31'b0, ERR}, 32'h1);
    check("t3_mem0", mem[0], 32'h0);

    // 4: misaligned source
    arm(t0);
    push_done(1'b1, t0);
    fire(32'h102, 32'h0, 9'd1, 1'b0, 1'b0);
    wait_done();

    // 5: IO address on an incrementing side
    arm(t0);
    push_done(1'b1, t0);
    fire(32'h100, IO, 9'd1, 1'b0, 1'b0);
    wait_done();

    // 6: source ending exactly at the last memory byte (legal), clears ERR
    arm(t0);
    push_wr(32'h008, 32'h5555_5555, t0 + 1);
    push_wr(32'h00C, 32'h6666_6666, t0 + 3);
    push_done(1'b0, t0 + 4);
    fire(32'h3F8, 32'h8, 9'd2, 1'b0, 1'b0);
    wait_done();

    // 7: fixed IO source, CPUIn changes before each read cycle
    arm(t0);
    cpu_in = 32'hAAAA_0001;
    push_wr(32'h040, 32'hAAAA_0001, t0 + 1);
    push_wr(32'h044, 32'hBBBB_0002, t0 + 3);
    push_wr(32'h048, 32'hCCCC_0003, t0 + 5);
    push_done(1'b0, t0 + 6);
    fire(IO, 32'h40, 9'd3, 1'b1, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    cpu_in = 32'hBBBB_0002;
    @(negedge CLK);
    @(negedge CLK);
    cpu_in = 32'hCCCC_0003;
    wait_done();
    check("t7_mem40", mem[16], 32'hAAAA_0001);
    check("t7_mem48", mem[18], 32'hCCCC_0003);

    // 8: memory buffer streamed out to the fixed IO destination
    sum0 = mem_sum();
    arm(t0);
    push_wr(IO, 32'h1111_1111, t0 + 1);
    push_wr(IO, 32'h2222_2222, t0 + 3);
    push_done(1'b0, t0 + 4);
    fire(32'h100, IO, 9'd2, 1'b0, 1'b1);
    wait_done();
    check("t8_cpu_out", cpu_out, 32'h2222_2222);
    check("t8_mem_sum", mem_sum(), sum0);

    // 9: reset during the second write cycle of a four-word copy
    arm(t0);
    push_wr(32'h300, 32'h1111_1111, t0 + 1);
    fire(32'h100, 32'h300, 9'd4, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("t9_we", {31'b0, WE}, 32'h0);
    check("t9_busy", {31'b0, BUSY}, 32'h0);
    check("t9_done", {31'b0, DONE}, 32'h0);
    check("t9_err", {31'b0, ERR}, 32'h0);
    check("t9_a", A, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    check("t9_mem300", mem[192], 32'h1111_1111);
    check("t9_mem304", mem[193], 32'h0);

    // 10: normal transfer after the reset
    arm(t0);
    push_wr(32'h380, 32'h1111_1111, t0 + 1);
    push_wr(32'h384, 32'h2222_2222, t0 + 3);
    push_done(1'b0, t0 + 4);
    fire(32'h100, 32'h380, 9'd2, 1'b0, 1'b0);
    wait_done();
    check("t10_mem380", mem[224], 32'h1111_1111);
    check("t10_mem384", mem[225], 32'h2222_2222);

    check("left_writes", 32'(exp_wr.size()), 32'h0);
    check("left_dones", 32'(exp_dn.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
